// File: rtl/ee552_pkg.sv
// Shared definitions for the partial-sum accumulator: packet field layout,
// opcodes, FSM state encoding and the output packet builder.
package ee552_pkg;

  localparam int PKT_W   = 30;
  localparam int SRC_LO  = 26;
  localparam int SRC_W   = 4;
  localparam int OPC_BIT = 25;
  localparam int POS_LO  = 20;
  localparam int POS_W   = 5;
  localparam int PSUM_LO = 0;
  localparam int ADDR_W  = 4;

  localparam logic OPC_PSUM  = 1'b0;
  localparam logic OPC_CLEAR = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ACC   = 3'd1,
    ST_FIRE  = 3'd2,
    ST_SEND  = 3'd3,
    ST_CLEAR = 3'd4
  } state_t;

  // Emitted packets always carry opcode bit 1 and a zero middle field.
  function automatic logic [PKT_W-1:0] make_out_pkt(input logic [ADDR_W-1:0] addr,
                                                     input logic [POS_W-1:0]  pos,
                                                     input logic              spike);
    make_out_pkt = {addr, 1'b1, pos, 19'b0, spike};
  endfunction

endpackage

// File: rtl/potential_rf.sv
// Membrane potential and contribution-mask storage, one entry per output
// position. One combinational read port, one write port, bulk clear.
module potential_rf #(
  parameter int N_ENT = 25,
  parameter int AW    = 5,
  parameter int DW    = 16,
  parameter int MW    = 5
) (
  input  logic          i_clk,
  input  logic          i_clear,
  input  logic [AW-1:0] i_rd_addr,
  output logic [DW-1:0] o_rd_pot,
  output logic [MW-1:0] o_rd_mask,
  input  logic          i_we,
  input  logic [AW-1:0] i_wr_addr,
  input  logic [DW-1:0] i_wr_pot,
  input  logic [MW-1:0] i_wr_mask
);

  logic [DW-1:0] r_pot  [N_ENT];
  logic [MW-1:0] r_mask [N_ENT];
  logic          w_rd_ok;
  logic          w_wr_ok;

  assign w_rd_ok = 32'(i_rd_addr) < N_ENT;
  assign w_wr_ok = 32'(i_wr_addr) < N_ENT;

  // Out-of-range addresses read as an empty entry instead of X.
  assign o_rd_pot  = w_rd_ok ? r_pot[i_rd_addr]  : '0;
  assign o_rd_mask = w_rd_ok ? r_mask[i_rd_addr] : '0;

  // Bulk clear wins over the single write port.
  always_ff @(posedge i_clk) begin
    if (i_clear) begin
      for (int i = 0; i < N_ENT; i++) begin
        r_pot[i]  <= '0;
        r_mask[i] <= '0;
      end
    end else if (i_we && w_wr_ok) begin
      r_pot[i_wr_addr]  <= i_wr_pot;
      r_mask[i_wr_addr] <= i_wr_mask;
    end
  end

endmodule

// File: rtl/psum_accumulator.sv
// Collects one partial sum per PPE row for each output position, then
// thresholds the accumulated potential and emits a spike packet.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | ready for one input packet
// ST_ACC   | validate captured psum, saturating add, set row mask bit
// ST_FIRE  | threshold compare, reset potential on spike, load packet
// ST_SEND  | hold out_packet until downstream takes it
// ST_CLEAR | zero every potential and mask
module psum_accumulator
  import ee552_pkg::*;
#(
  parameter int                NUM_ROWS  = 5,
  parameter int                NUM_POS   = 25,
  parameter int                PSUM_W    = 13,
  parameter int                POT_W     = 16,
  parameter int unsigned       THRESHOLD = 64,
  parameter logic [ADDR_W-1:0] OUT_ADDR  = 4'd10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [PKT_W-1:0] in_packet,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [PKT_W-1:0] out_packet,
  output logic             err,
  output logic             busy
);

  state_t              r_state;
  state_t              w_next;
  logic [SRC_W-1:0]    r_src;
  logic [POS_W-1:0]    r_pos;
  logic [PSUM_W-1:0]   r_psum;
  logic [PKT_W-1:0]    r_out_packet;
  logic                r_err;

  logic [POT_W-1:0]    w_rd_pot;
  logic [NUM_ROWS-1:0] w_rd_mask;
  logic                w_we;
  logic [POT_W-1:0]    w_wr_pot;
  logic [NUM_ROWS-1:0] w_wr_mask;
  logic                w_clr;

  logic                w_accept;
  logic                w_src_ok;
  logic                w_pos_ok;
  logic [NUM_ROWS-1:0] w_src_bit;
  logic                w_psum_ok;
  logic [NUM_ROWS-1:0] w_new_mask;
  logic [POT_W:0]      w_sum_ext;
  logic [POT_W-1:0]    w_sum;
  logic                w_spike;
  logic                w_unused_pad;

  assign w_unused_pad = ^in_packet[POS_LO-1:PSUM_LO+PSUM_W];

  assign w_accept   = in_valid && in_ready;
  assign w_src_ok   = 32'(r_src) < NUM_ROWS;
  assign w_pos_ok   = 32'(r_pos) < NUM_POS;
  assign w_src_bit  = w_src_ok ? (NUM_ROWS'(1) << r_src) : '0;
  assign w_psum_ok  = w_src_ok && w_pos_ok && ((w_rd_mask & w_src_bit) == '0);
  assign w_new_mask = w_rd_mask | w_src_bit;
  assign w_sum_ext  = {1'b0, w_rd_pot} + (POT_W+1)'(r_psum);
  assign w_sum      = w_sum_ext[POT_W] ? '1 : w_sum_ext[POT_W-1:0];
  assign w_spike    = 32'(w_rd_pot) >= THRESHOLD;

  potential_rf #(
    .N_ENT (NUM_POS),
    .AW    (POS_W),
    .DW    (POT_W),
    .MW    (NUM_ROWS)
  ) u_rf (
    .i_clk     (clk),
    .i_clear   (w_clr),
    .i_rd_addr (r_pos),
    .o_rd_pot  (w_rd_pot),
    .o_rd_mask (w_rd_mask),
    .i_we      (w_we),
    .i_wr_addr (r_pos),
    .i_wr_pot  (w_wr_pot),
    .i_wr_mask (w_wr_mask)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  // Next-state decode.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          case (in_packet[OPC_BIT])
            OPC_PSUM: w_next = ST_ACC;
            default:  w_next = ST_CLEAR;
          endcase
        end
      end
      ST_ACC:   w_next = (w_psum_ok && (&w_new_mask)) ? ST_FIRE : ST_IDLE;
      ST_FIRE:  w_next = ST_SEND;
      ST_SEND:  w_next = out_ready ? ST_IDLE : ST_SEND;
      ST_CLEAR: w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  // Handshake outputs and storage write controls; reset also clears storage.
  always_comb begin
    in_ready  = rst_n && (r_state == ST_IDLE);
    out_valid = (r_state == ST_SEND);
    busy      = (r_state != ST_IDLE);
    w_we      = 1'b0;
    w_wr_pot  = '0;
    w_wr_mask = '0;
    w_clr     = !rst_n;
    case (r_state)
      ST_ACC: begin
        if (w_psum_ok) begin
          w_we      = 1'b1;
          w_wr_pot  = w_sum;
          w_wr_mask = w_new_mask;
        end
      end
      ST_FIRE: begin
        w_we      = 1'b1;
        w_wr_pot  = w_spike ? '0 : w_rd_pot;
        w_wr_mask = '0;
      end
      ST_CLEAR: w_clr = 1'b1;
      default: ;
    endcase
  end

  // Captured request fields, sticky error and the outgoing packet register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_src        <= '0;
      r_pos        <= '0;
      r_psum       <= '0;
      r_out_packet <= '0;
      r_err        <= 1'b0;
    end else begin
      if (w_accept) begin
        r_src  <= in_packet[SRC_LO +: SRC_W];
        r_pos  <= in_packet[POS_LO +: POS_W];
        r_psum <= in_packet[PSUM_LO +: PSUM_W];
      end
      if ((r_state == ST_ACC) && !w_psum_ok) r_err <= 1'b1;
      if (r_state == ST_FIRE) r_out_packet <= make_out_pkt(OUT_ADDR, r_pos, w_spike);
    end
  end

  assign out_packet = r_out_packet;
  assign err        = r_err;

endmodule
